// File: rtl/melody_pkg.sv
// Shared constants for the autoplay melody sequencer: note scan codes,
// FSM state encoding, song-table entry layout and the default song.
package melody_pkg;

  localparam int SCAN_W  = 8;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = SCAN_W + DUR_W;

  localparam logic [SCAN_W-1:0] NOTE_DO   = 8'h23;
  localparam logic [SCAN_W-1:0] NOTE_RE   = 8'h2D;
  localparam logic [SCAN_W-1:0] NOTE_MI   = 8'h3A;
  localparam logic [SCAN_W-1:0] NOTE_FA   = 8'h2B;
  localparam logic [SCAN_W-1:0] NOTE_SOL  = 8'h1B;
  localparam logic [SCAN_W-1:0] NOTE_LA   = 8'h4B;
  localparam logic [SCAN_W-1:0] NOTE_SI   = 8'h21;
  localparam logic [SCAN_W-1:0] NOTE_MUTE = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_NOTE,
    ST_GAP
  } state_t;

  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [SCAN_W-1:0] scan,
                                                  input logic [DUR_W-1:0]  dur);
    return {scan, dur};
  endfunction

  // Entry 0 sits in the least-significant slice; the final entry is the end marker.
  localparam logic [16*ENTRY_W-1:0] DEFAULT_SONG = {
    mk_entry(NOTE_MUTE, 4'd0), mk_entry(NOTE_DO,  4'd8),
    mk_entry(NOTE_RE,   4'd2), mk_entry(NOTE_MI,  4'd2),
    mk_entry(NOTE_FA,   4'd2), mk_entry(NOTE_SOL, 4'd2),
    mk_entry(NOTE_LA,   4'd2), mk_entry(NOTE_SI,  4'd2),
    mk_entry(NOTE_MUTE, 4'd2), mk_entry(NOTE_SI,  4'd4),
    mk_entry(NOTE_LA,   4'd4), mk_entry(NOTE_SOL, 4'd4),
    mk_entry(NOTE_FA,   4'd4), mk_entry(NOTE_MI,  4'd4),
    mk_entry(NOTE_RE,   4'd4), mk_entry(NOTE_DO,  4'd4)
  };

endpackage

// File: rtl/melody_song_rom.sv
// Combinational song-table lookup: index -> {scan, dur}, contents supplied
// as a packed parameter so a bench can substitute its own song.
module song_rom
  import melody_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter logic [SONG_LEN*ENTRY_W-1:0] SONG = DEFAULT_SONG,
  localparam int AW = $clog2(SONG_LEN)
) (
  input  logic [AW-1:0]     idx,
  output logic [SCAN_W-1:0] scan,
  output logic [DUR_W-1:0]  dur
);

  logic [ENTRY_W-1:0] rom [SONG_LEN];

  for (genvar gi = 0; gi < SONG_LEN; gi++) begin : g_rom
    assign rom[gi] = SONG[gi*ENTRY_W +: ENTRY_W];
  end

  assign {scan, dur} = rom[idx];

endmodule

// File: rtl/melody_seq.sv
// Autoplay sequencer: walks the song table, times notes and articulation
// gaps in ticks, and lets live keyboard presses override and pause the song.
module melody_seq
  import melody_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int SONG_LEN = 16,
  parameter logic [SONG_LEN*ENTRY_W-1:0] SONG = DEFAULT_SONG,
  localparam int AW = $clog2(SONG_LEN),
  localparam int TW = $clog2(TICK_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SCAN_W-1:0] kb_scan,
  input  logic              kb_valid,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [SCAN_W-1:0] note_scan,
  output logic              busy,
  output logic [AW-1:0]     step_idx
);

  // One extra index bit lets "ran past the last entry" reach FETCH and be
  // handled exactly like an end marker.
  localparam logic [AW:0]   IDX_END   = (AW+1)'(SONG_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t            state_reg;
  logic [AW:0]       idx_reg;
  logic [SCAN_W-1:0] cur_scan_reg;
  logic [DUR_W-1:0]  cur_dur_reg;
  logic [TW-1:0]     tick_cnt_reg;
  logic [DUR_W-1:0]  dur_cnt_reg;
  logic              busy_reg;
  logic [SCAN_W-1:0] note_scan_reg;

  logic [SCAN_W-1:0] rom_scan;
  logic [DUR_W-1:0]  rom_dur;
  logic              tick_last;
  logic              song_end;

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .SONG     (SONG)
  ) u_rom (
    .idx  (idx_reg[AW-1:0]),
    .scan (rom_scan),
    .dur  (rom_dur)
  );

  assign tick_last = (tick_cnt_reg == TICK_LAST);
  assign song_end  = (idx_reg == IDX_END) || (rom_dur == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      cur_scan_reg  <= NOTE_MUTE;
      cur_dur_reg   <= '0;
      tick_cnt_reg  <= '0;
      dur_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      note_scan_reg <= NOTE_MUTE;
    end else begin
      // Stop mutes in the same edge that returns the FSM to IDLE.
      if (kb_valid)
        note_scan_reg <= kb_scan;
      else if (!stop && state_reg == ST_NOTE)
        note_scan_reg <= cur_scan_reg;
      else
        note_scan_reg <= NOTE_MUTE;

      if (stop) begin
        state_reg    <= ST_IDLE;
        idx_reg      <= '0;
        tick_cnt_reg <= '0;
        dur_cnt_reg  <= '0;
        busy_reg     <= 1'b0;
      end else if (!kb_valid) begin
        case (state_reg)
          ST_IDLE: begin
            if (play) begin
              state_reg <= ST_FETCH;
              busy_reg  <= 1'b1;
            end
          end
          ST_FETCH: begin
            cur_scan_reg <= rom_scan;
            cur_dur_reg  <= rom_dur;
            tick_cnt_reg <= '0;
            dur_cnt_reg  <= '0;
            if (song_end) begin
              idx_reg <= '0;
              if (!loop_en) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              state_reg <= ST_NOTE;
            end
          end
          ST_NOTE: begin
            if (tick_last) begin
              tick_cnt_reg <= '0;
              if (dur_cnt_reg == cur_dur_reg - 4'd1) begin
                dur_cnt_reg <= '0;
                state_reg   <= ST_GAP;
              end else begin
                dur_cnt_reg <= dur_cnt_reg + 4'd1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
          end
          ST_GAP: begin
            if (tick_last) begin
              tick_cnt_reg <= '0;
              idx_reg      <= idx_reg + (AW+1)'(1);
              state_reg    <= ST_FETCH;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + TW'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_scan = note_scan_reg;
  assign busy      = busy_reg;
  assign step_idx  = idx_reg[AW-1:0];

endmodule

// File: tb/tb_melody_seq.sv
// Randomized and directed bench for melody_seq against a timeline model:
// each entry is a run of unpaused cycles (fetch, note, gap) indexed by elapsed time.
module tb_melody_seq;
  import melody_pkg::*;

  localparam int TD  = 4;
  localparam int LEN = 4;
  localparam int AW  = 2;
  localparam logic [LEN*ENTRY_W-1:0] TEST_SONG = {
    mk_entry(NOTE_SOL, 4'd0), mk_entry(NOTE_MI, 4'd1),
    mk_entry(NOTE_MUTE, 4'd1), mk_entry(NOTE_DO, 4'd2)
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    kb_scan = 8'h00;
  logic          kb_valid = 1'b0;
  logic          play = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [7:0]    note_scan;
  logic          busy;
  logic [AW-1:0] step_idx;

  always #5 clk = ~clk;

  melody_seq #(
    .TICK_DIV (TD),
    .SONG_LEN (LEN),
    .SONG     (TEST_SONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kb_scan   (kb_scan),
    .kb_valid  (kb_valid),
    .play      (play),
    .stop      (stop),
    .loop_en   (loop_en),
    .note_scan (note_scan),
    .busy      (busy),
    .step_idx  (step_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";

  logic [7:0] song_scan [LEN] = '{8'h23, 8'h05, 8'h3A, 8'h1B};
  int         song_dur  [LEN] = '{2, 1, 1, 0};

  // Model: playing flag, entry index, elapsed unpaused cycles within the entry.
  bit         m_play = 1'b0;
  int         m_idx  = 0;
  int         m_e    = 0;
  logic [7:0] m_note = 8'h05;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit pl, input bit st, input bit kv,
                            input logic [7:0] ks, input bit le);
    if (r) begin
      m_play = 1'b0; m_idx = 0; m_e = 0; m_note = 8'h05;
      return;
    end
    if (kv)
      m_note = ks;
    else if (!st && m_play && m_idx < LEN && m_e >= 1 && m_e <= song_dur[m_idx] * TD)
      m_note = song_scan[m_idx];
    else
      m_note = 8'h05;

    if (st) begin
      m_play = 1'b0; m_idx = 0; m_e = 0;
    end else if (!kv) begin
      if (!m_play) begin
        if (pl) begin m_play = 1'b1; m_idx = 0; m_e = 0; end
      end else if (m_e == 0 && (m_idx >= LEN || song_dur[m_idx] == 0)) begin
        m_idx  = 0;
        m_play = le;
      end else begin
        m_e++;
        if (m_e == (song_dur[m_idx] + 1) * TD + 1) begin
          m_e = 0;
          m_idx++;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit pl, input bit st, input bit kv,
                       input logic [7:0] ks, input bit le);
    @(negedge clk);
    rst = r; play = pl; stop = st; kb_valid = kv; kb_scan = ks; loop_en = le;
    @(posedge clk);
    model_step(r, pl, st, kv, ks, le);
    #1;
    check("note_scan", 32'(note_scan), 32'(m_note));
    check("busy", 32'(busy), 32'(m_play));
    check("step_idx", 32'(step_idx), 32'(m_idx % LEN));
  endtask

  task automatic idle_cycles(input int n, input bit le);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, le);
  endtask

  int cnt_a, cnt_b;

  initial begin
    // Reset, with play asserted during it.
    phase = "reset";
    $display("[TB] reset 3 cycles with play during reset");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_note", 32'(note_scan), 32'h05);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_idx", 32'(step_idx), 32'd0);
    idle_cycles(2, 1'b0);

    // Basic song: 32 busy cycles, DO audible for 8.
    phase = "basic";
    $display("[TB] play basic song");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cnt_a = 32'(busy); cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      cnt_a += 32'(busy);
      if (note_scan == 8'h23) cnt_b++;
    end
    check("basic_busy_cycles", 32'(cnt_a), 32'd32);
    check("basic_do_cycles", 32'(cnt_b), 32'd8);
    check("basic_end_idx", 32'(step_idx), 32'd0);

    // Loop: busy never drops.
    phase = "loop";
    $display("[TB] play with loop_en");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    cnt_a = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      if (!busy) cnt_a++;
    end
    check("loop_busy_drops", 32'(cnt_a), 32'd0);
    $display("[TB] stop loop");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    idle_cycles(2, 1'b0);

    // Keyboard override mid-DO.
    phase = "keyboard";
    $display("[TB] play then hold key 4B for 10 cycles mid-DO");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 50; i++) begin
      if (i >= 5 && i < 15) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h4B, 1'b0);
      else                  cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      if (note_scan == 8'h23) cnt_a++;
      if (note_scan == 8'h4B) cnt_b++;
    end
    check("kb_do_cycles", 32'(cnt_a), 32'd8);
    check("kb_key_cycles", 32'(cnt_b), 32'd10);

    // Stop and play together mid-song, then a clean restart.
    phase = "collision";
    $display("[TB] play, then stop+play together");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(16, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check("coll_busy", 32'(busy), 32'd0);
    check("coll_note", 32'(note_scan), 32'h05);
    check("coll_idx", 32'(step_idx), 32'd0);
    $display("[TB] replay after collision");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycles(2, 1'b0);
    check("replay_first_note", 32'(note_scan), 32'h23);

    // Play while busy is ignored; reset in NOTE.
    phase = "busy_play";
    idle_cycles(13, 1'b0);
    $display("[TB] play while busy");
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("busy_play_idx", 32'(step_idx), 32'd1);
    idle_cycles(10, 1'b0);
    $display("[TB] reset in NOTE");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rst_note", 32'(note_scan), 32'h05);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(step_idx), 32'd0);

    // Random traffic.
    phase = "random";
    begin
      int kb_left = 0;
      logic [7:0] ks = 8'h00;
      bit le = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit r, pl, st;
        if (i % 200 == 0) le = bit'($urandom_range(0, 1));
        if (kb_left == 0 && $urandom_range(0, 29) == 0) begin
          kb_left = $urandom_range(1, 12);
          ks = 8'($urandom);
        end
        r  = ($urandom_range(0, 599) == 0);
        pl = ($urandom_range(0, 39) == 0);
        st = ($urandom_range(0, 149) == 0);
        if (r || pl || st) $display("[TB] rnd cycle %0d rst=%0b play=%0b stop=%0b", i, r, pl, st);
        cycle(r, pl, st, kb_left > 0, ks, le);
        if (kb_left > 0) kb_left--;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
# melody_seq

Autoplay sequencer for the square-wave tone generator: steps through a fixed song table of (scan code, duration) entries and drives the tone generator's 8-bit note-select input. Live keyboard presses take priority and pause the song. Sits between the PS/2 scan-code decoder and the tone generator. Rests and idle are encoded as the mute code 8'h05.

## Interface
- TICK_DIV, 10_000_000: clk cycles per duration tick (100 ms at 100 MHz); must be ≥ 2
- SONG_LEN, 16: song table depth; power of two, ≤ 256
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- kb_scan  in  8  live keyboard scan code
- kb_valid  in  1  key currently held; kb_scan is valid
- play  in  1  single-cycle pulse: start song from entry 0
- stop  in  1  single-cycle pulse: abort song
- loop_en  in  1  restart at entry 0 after end of song instead of stopping
- note_scan  out  8  note select to tone generator (registered)
- busy  out  1  song in progress (state ≠ IDLE)
- step_idx  out  log2(SONG_LEN)  current table index

## Operation
- Table entry = {scan[7:0], dur[3:0]}; dur = 0 is the end-of-song marker; scan 8'h05 is a rest.
- States: IDLE, FETCH, NOTE, GAP.
  - IDLE: idx = 0. play → FETCH.
  - FETCH (1 cycle): latch entry[idx] into cur_scan/cur_dur. If dur = 0: go to FETCH with idx = 0 when loop_en, else IDLE. Otherwise go to NOTE with tick_cnt = 0 and dur_cnt = 0.
  - NOTE: lasts cur_dur ticks, then GAP.
  - GAP: 1 tick of mute for articulation. Then idx+1 and FETCH.
  - Index wrap: past SONG_LEN−1 it is treated as end of song (same rule as dur = 0).
- Tick counter runs 0..TICK_DIV−1 only in NOTE/GAP and only while kb_valid = 0. While kb_valid = 1 all sequencer counters and state hold (pause).
- Output mux, registered:
  - kb_valid → kb_scan
  - else NOTE → cur_scan
  - else → 8'h05
- stop in any state → IDLE next cycle, idx = 0.
- play while busy is ignored.
- play and stop in the same cycle: stop wins.
- Keyboard priority applies in IDLE too, so the block always forwards live keys.

## Timing
- Reset values: note_scan = 8'h05, busy = 0, step_idx = 0; state IDLE; all counters 0.
- play at cycle t:
  - FETCH at t+1
  - NOTE at t+2
  - note_scan = cur_scan from t+3 (one-cycle output register)
- NOTE duration: exactly cur_dur × TICK_DIV unpaused cycles.
- GAP duration: exactly TICK_DIV unpaused cycles.
- Per-entry period: (cur_dur+1)×TICK_DIV + 1 cycles.
- kb_valid rise/fall reaches note_scan after 1 cycle. Paused cycles extend the current NOTE/GAP one-for-one, with no lost or extra ticks.
- rst mid-song: all state returns to reset values on the next edge; rst dominates play and stop.
- busy and step_idx are registered, valid in the same cycle as the state.

## Structure
- Shared package melody_pkg:
  - note constants: DO 8'h23, RE 8'h2D, MI 8'h3A, FA 8'h2B, SOL 8'h1B, LA 8'h4B, SI 8'h21, MUTE 8'h05
  - state encoding
  - table-entry field widths
- Sub-module song_rom: combinational lookup, index → {scan, dur}, contents from melody_pkg constants. The sim bench overrides it with a short test song.
- The tick/duration counters and the FSM stay in melody_seq.

## Test plan
All scenarios use TICK_DIV = 4 and a test song of {DO,2}, {MUTE,1}, {MI,1}, {x,0}.
- **Reset**: rst for 3 cycles → note_scan = 8'h05, busy = 0, step_idx = 0; play during rst is ignored.
- **Basic song**: play pulse → busy = 1 from t+1.
  - note_scan = 8'h23 from t+3 for 8 cycles, then 8'h05 for 4 (GAP) + 1 (FETCH).
  - Rest entry: 8'h05 for 9 cycles.
  - MI: 8'h3A for 4 cycles, then 8'h05.
  - Song ends → busy = 0 at end marker, step_idx = 0.
- **Loop**: same stimulus with loop_en = 1 → after end marker, next FETCH reads idx 0 and 8'h23 reappears; busy never drops.
- **Keyboard override**: kb_valid = 1 with kb_scan = 8'h4B for 10 cycles mid-DO → note_scan = 8'h4B during the pause, 8'h23 resumes afterwards. Total DO time is still 8 unpaused cycles.
- **Stop/play collision**: stop and play in the same cycle mid-song → IDLE next cycle, note_scan = 8'h05, step_idx = 0. A later play restarts from entry 0.
- **Ignored play / reset mid-note**: play while busy → no restart, idx unchanged. rst asserted in NOTE → reset values on the next edge.
